// File: rtl/zx_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : zx_wr_arb
// Purpose  : Round-robin arbiter for two byte requesters, timed cs/wr write cycle
// Revision : 1.0 - initial release
// ============================================================================
module zx_wr_arb #(
  parameter int DW      = 8,
  parameter int T_SETUP = 1,
  parameter int T_WR    = 2,
  parameter int T_HOLD  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  output logic          cs,
  output logic          wr,
  output logic [DW-1:0] dout,
  output logic          busy
);

  generate
    if (T_SETUP < 1 || T_SETUP > 255 || T_WR < 1 || T_WR > 255 ||
        T_HOLD < 1 || T_HOLD > 255) begin : g_bad_param
      $error("zx_wr_arb: T_SETUP, T_WR and T_HOLD must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] C_SETUP_LAST = 8'(T_SETUP - 1);
  localparam logic [7:0] C_WR_LAST    = 8'(T_WR - 1);
  localparam logic [7:0] C_HOLD_LAST  = 8'(T_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic          r_last, w_last_nxt;
  logic [DW-1:0] w_dout_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 8'd1;
    w_last_nxt  = r_last;
    w_dout_nxt  = dout;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 8'd0;
        // r_last names the previous winner; on contention the other side wins
        if (req0 && (!req1 || r_last)) begin
          w_state_nxt = SETUP;
          w_last_nxt  = 1'b0;
          w_dout_nxt  = din0;
        end else if (req1) begin
          w_state_nxt = SETUP;
          w_last_nxt  = 1'b1;
          w_dout_nxt  = din1;
        end
      end
      SETUP: begin
        if (r_cnt == C_SETUP_LAST) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = 8'd0;
        end
      end
      STROBE: begin
        if (r_cnt == C_WR_LAST) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = 8'd0;
        end
      end
      HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they align with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_last  <= 1'b1;
      dout    <= '0;
      cs      <= 1'b1;
      wr      <= 1'b1;
      busy    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      dout    <= w_dout_nxt;
      cs      <= (w_state_nxt == IDLE);
      wr      <= (w_state_nxt != STROBE);
      busy    <= (w_state_nxt != IDLE);
      ack0    <= (w_state_nxt == HOLD) && (w_cnt_nxt == C_HOLD_LAST) && !w_last_nxt;
      ack1    <= (w_state_nxt == HOLD) && (w_cnt_nxt == C_HOLD_LAST) &&  w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zx_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_zx_wr_arb
// Purpose  : Self-checking bench for zx_wr_arb (default and long timing)
// Revision : 1.0 - initial release
// ============================================================================
module tb_zx_wr_arb;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_n, req0, req1;
  logic [7:0] din0, din1;
  logic [1:0] cs_v, wr_v, ack0_v, ack1_v, busy_v;
  logic [7:0] dout_v [2];

  zx_wr_arb #(.DW(8), .T_SETUP(1), .T_WR(2), .T_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .din0(din0), .ack0(ack0_v[0]),
    .req1(req1), .din1(din1), .ack1(ack1_v[0]),
    .cs(cs_v[0]), .wr(wr_v[0]), .dout(dout_v[0]), .busy(busy_v[0])
  );

  zx_wr_arb #(.DW(8), .T_SETUP(3), .T_WR(5), .T_HOLD(2)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .din0(din0), .ack0(ack0_v[1]),
    .req1(req1), .din1(din1), .ack1(ack1_v[1]),
    .cs(cs_v[1]), .wr(wr_v[1]), .dout(dout_v[1]), .busy(busy_v[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference: a busy flag plus a cycle index into the write
  int         ts [2] = '{1, 3};
  int         tw [2] = '{2, 5};
  int         th [2] = '{1, 2};
  int         act[2], ph[2], win[2], lst[2];
  logic [7:0] dat[2];

  function automatic void mdl_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; ph[k] = 0; win[k] = 0; lst[k] = 1; dat[k] = 8'h00;
    end
  endfunction

  function automatic void mdl_update();
    if (!rst_n) begin
      mdl_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (act[k] == 0) begin
        if (req0 || req1) begin
          win[k] = (req0 && (!req1 || lst[k] == 1)) ? 0 : 1;
          lst[k] = win[k];
          dat[k] = (win[k] == 0) ? din0 : din1;
          act[k] = 1;
          ph[k]  = 0;
        end
      end else if (ph[k] == ts[k] + tw[k] + th[k] - 1) begin
        act[k] = 0;
      end else begin
        ph[k] = ph[k] + 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic check_models();
    for (int k = 0; k < 2; k++) begin
      int  len;
      bit  strobe, last_cyc;
      len      = ts[k] + tw[k] + th[k];
      strobe   = (act[k] == 1) && (ph[k] >= ts[k]) && (ph[k] < ts[k] + tw[k]);
      last_cyc = (act[k] == 1) && (ph[k] == len - 1);
      chk($sformatf("m%0d.cs", k),   32'(cs_v[k]),   32'(act[k] == 0));
      chk($sformatf("m%0d.wr", k),   32'(wr_v[k]),   32'(!strobe));
      chk($sformatf("m%0d.dout", k), 32'(dout_v[k]), 32'(dat[k]));
      chk($sformatf("m%0d.ack0", k), 32'(ack0_v[k]), 32'(last_cyc && win[k] == 0));
      chk($sformatf("m%0d.ack1", k), 32'(ack1_v[k]), 32'(last_cyc && win[k] == 1));
      chk($sformatf("m%0d.busy", k), 32'(busy_v[k]), 32'(act[k] == 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_update();
    @(negedge clk);
    check_models();
  endtask

  typedef struct {
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    logic       cs;
    logic       wr;
    logic [7:0] dout;
    logic       a0;
    logic       a1;
    logic       busy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r0, logic [7:0] d0, logic r1, logic [7:0] d1,
                              logic cs, logic wr, logic [7:0] dout,
                              logic a0, logic a1, logic busy);
    vec_t v;
    v = '{r0, d0, r1, d1, cs, wr, dout, a0, a1, busy};
    tbl.push_back(v);
  endfunction

  task automatic chk_outs0(input string nm, input logic c, input logic w,
                           input logic [7:0] d, input logic a0, input logic a1,
                           input logic b);
    chk({nm, ".cs"},   32'(cs_v[0]),   32'(c));
    chk({nm, ".wr"},   32'(wr_v[0]),   32'(w));
    chk({nm, ".dout"}, 32'(dout_v[0]), 32'(d));
    chk({nm, ".ack0"}, 32'(ack0_v[0]), 32'(a0));
    chk({nm, ".ack1"}, 32'(ack1_v[0]), 32'(a1));
    chk({nm, ".busy"}, 32'(busy_v[0]), 32'(b));
  endtask

  initial begin
    int cs_cnt, wr_cnt, a0_cnt, a1_cnt, ack_at;
    bit done;

    // Contention from reset: grants alternate 0,1,0,1 with one idle cycle between
    for (int p = 0; p < 2; p++) begin
      add(1, 8'h11, 1, 8'h22, 0, 1, 8'h11, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 0, 8'h11, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 0, 8'h11, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 1, 8'h11, 1, 0, 1);
      add(1, 8'h11, 1, 8'h22, 1, 1, 8'h11, 0, 0, 0);
      add(1, 8'h11, 1, 8'h22, 0, 1, 8'h22, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 0, 8'h22, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 0, 8'h22, 0, 0, 1);
      add(1, 8'h11, 1, 8'h22, 0, 1, 8'h22, 0, 1, 1);
      add(p == 0, 8'h11, p == 0, 8'h22, 1, 1, 8'h22, 0, 0, 0);
    end
    // Single write of A5 by requester 0
    add(1, 8'hA5, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 1);
    add(1, 8'hA5, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 1);
    add(1, 8'hA5, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 1);
    add(1, 8'hA5, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 1);
    add(0, 8'hA5, 0, 8'h00, 1, 1, 8'hA5, 0, 0, 0);
    add(0, 8'h00, 0, 8'h00, 1, 1, 8'hA5, 0, 0, 0);

    // Reset held while inputs toggle
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    mdl_reset();
    @(negedge clk);
    chk_outs0("rst_init", 1, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      req0 = 1'(i); req1 = 1'(i >> 1);
      din0 = 8'($urandom); din1 = 8'($urandom);
      step();
      chk_outs0("rst_hold", 1, 1, 8'h00, 0, 0, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      req0 = tbl[i].r0; din0 = tbl[i].d0;
      req1 = tbl[i].r1; din1 = tbl[i].d1;
      step();
      chk_outs0($sformatf("vec%0d", i), tbl[i].cs, tbl[i].wr, tbl[i].dout,
                tbl[i].a0, tbl[i].a1, tbl[i].busy);
    end

    // Data stability: din0 changes during STROBE must not reach dout
    req0 = 1'b1; din0 = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stab%0d.dout", i), 32'(dout_v[0]), 32'h3C);
      chk($sformatf("stab%0d.cs", i),   32'(cs_v[0]),   32'(i == 4));
      chk($sformatf("stab%0d.ack0", i), 32'(ack0_v[0]), 32'(i == 3));
      if (i == 1) din0 = 8'hFF;
      if (i == 3) req0 = 1'b0;
    end

    // Asynchronous reset during STROBE, then a fresh transaction for requester 1
    req1 = 1'b1; din1 = 8'h5A;
    step();
    step();
    chk("mid.wr_before", 32'(wr_v[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk_outs0("mid_rst", 1, 1, 8'h00, 0, 0, 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    cs_cnt = 0; a0_cnt = 0; a1_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cs_v[0] == 1'b0) cs_cnt++;
      if (ack0_v[0]) a0_cnt++;
      if (ack1_v[0]) begin
        a1_cnt++;
        chk("mid.dout_at_ack", 32'(dout_v[0]), 32'h5A);
        req1 = 1'b0;
      end
    end
    chk("mid.cs_low_cycles", 32'(cs_cnt), 32'd4);
    chk("mid.ack1_count",    32'(a1_cnt), 32'd1);
    chk("mid.ack0_count",    32'(a0_cnt), 32'd0);

    // Long timing instance: 3/5/2
    req0 = 1'b0; req1 = 1'b0;
    repeat (15) step();
    req0 = 1'b1; din0 = 8'h77;
    cs_cnt = 0; wr_cnt = 0; ack_at = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (cs_v[1] == 1'b0) cs_cnt++;
      if (wr_v[1] == 1'b0) wr_cnt++;
      if (ack0_v[1]) begin
        ack_at = cs_cnt;
        req0 = 1'b0;
      end
      if (ack_at != 0 && cs_v[1] == 1'b1) done = 1'b1;
    end
    chk("t6.completed",   32'(done),   32'd1);
    chk("t6.cs_low",      32'(cs_cnt), 32'd10);
    chk("t6.wr_low",      32'(wr_cnt), 32'd5);
    chk("t6.ack_cycle",   32'(ack_at), 32'd10);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
